// File: rtl/xgriscv_retire_monitor_if.sv
// Retire-stream and trace-readout bundle between the xgriscv writeback stage and its monitor.
// The master drives retirements and trace pops, and the slave returns the trace readout.
interface xgriscv_retire_monitor_if #(
   parameter int ADDR_W      = 32,
   parameter int TRACE_DEPTH = 8
) ();
   logic                         retire_valid;
   logic [ADDR_W-1:0]            retire_pc;
   logic                         trace_rd_en;
   logic [ADDR_W-1:0]            trace_rd_data;
   logic                         trace_rd_valid;
   logic [$clog2(TRACE_DEPTH):0] trace_count;

   modport master (
      output retire_valid, retire_pc, trace_rd_en,
      input  trace_rd_data, trace_rd_valid, trace_count
   );

   modport slave (
      input  retire_valid, retire_pc, trace_rd_en,
      output trace_rd_data, trace_rd_valid, trace_count
   );
endinterface

// File: rtl/xgriscv_retire_monitor.sv
// Retire-end observer for xgriscv_pipeline: done on END_PC retire, watchdog timeout, cycle/retire counts.
// Define RETIRE_TRACE_EN to keep a circular history of the last TRACE_DEPTH retired PCs.
module xgriscv_retire_monitor #(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] END_PC      = 'h80000078,
   parameter int                WDOG_CYCLES = 1024,
   parameter int                CNT_W       = 32,
   parameter int                TRACE_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   xgriscv_retire_monitor_if.slave    ret_if,
   output logic                       done,
   output logic                       timeout,
   output logic [CNT_W-1:0]           cycle_cnt,
   output logic [CNT_W-1:0]           retire_cnt
);
   localparam int WD_W = $clog2(WDOG_CYCLES);
   localparam int TC_W = $clog2(TRACE_DEPTH) + 1;
   localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_e;

   state_e            state_q, state_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0]  ret_q, ret_d;
   logic              done_q, timeout_q;
   logic              capture;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      wdog_d  = wdog_q;
      cyc_d   = cyc_q;
      ret_d   = ret_q;
      capture = 1'b0;
      if (state_q == S_IDLE || state_q == S_RUN) begin
         capture = ret_if.retire_valid;
         if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
         if (ret_if.retire_valid) begin
            // A retire on the expiry cycle still counts as progress and beats the watchdog.
            if (ret_q != '1) ret_d = ret_q + 1'b1;
            wdog_d  = '0;
            state_d = (ret_if.retire_pc == END_PC) ? S_DONE : S_RUN;
         end else if (wdog_q == WDOG_LAST) begin
            state_d = S_TIMEOUT;
         end else begin
            wdog_d = wdog_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q   <= S_IDLE;
         wdog_q    <= '0;
         cyc_q     <= '0;
         ret_q     <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wdog_q    <= wdog_d;
         cyc_q     <= cyc_d;
         ret_q     <= ret_d;
         done_q    <= (state_d == S_DONE);
         timeout_q <= (state_d == S_TIMEOUT);
      end
   end

   assign done       = done_q;
   assign timeout    = timeout_q;
   assign cycle_cnt  = cyc_q;
   assign retire_cnt = ret_q;

`ifdef RETIRE_TRACE_EN
   localparam int PTR_W = $clog2(TRACE_DEPTH);

   logic [ADDR_W-1:0] trace_mem_q [TRACE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [TC_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              full, pop, ovw;

   // A write into a full buffer drops the oldest entry, so the read pointer also advances past it.
   always_comb begin
      full       = (cnt_q == TC_W'(TRACE_DEPTH));
      pop        = ret_if.trace_rd_en && (cnt_q != '0);
      ovw        = capture && full;
      wr_ptr_d   = capture ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop) + PTR_W'(ovw);
      cnt_d      = cnt_q + TC_W'(capture) - TC_W'(pop) - TC_W'(ovw);
      rd_valid_d = pop;
      rd_data_d  = pop ? trace_mem_q[rd_ptr_q] : rd_data_q;
   end

   // NOTE: the history array is not reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (capture) trace_mem_q[wr_ptr_q] <= ret_if.retire_pc;
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign ret_if.trace_rd_data  = rd_data_q;
   assign ret_if.trace_rd_valid = rd_valid_q;
   assign ret_if.trace_count    = cnt_q;
`else
   assign ret_if.trace_rd_data  = '0;
   assign ret_if.trace_rd_valid = 1'b0;
   assign ret_if.trace_count    = {TC_W{1'b0}};
`endif
endmodule

// File: tb/tb_xgriscv_retire_monitor.sv
// Directed bench for xgriscv_retire_monitor with a short watchdog (16 cycles) and a depth-8 trace.
module tb_xgriscv_retire_monitor;
   localparam int          ADDR_W = 32;
   localparam int          CNT_W  = 32;
   localparam int          WDOG   = 16;
   localparam int          DEPTH  = 8;
   localparam logic [31:0] END_PC = 32'h80000078;

   logic             clk = 1'b0;
   logic             rstn;
   logic             done, timeout;
   logic [CNT_W-1:0] cycle_cnt, retire_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   xgriscv_retire_monitor_if #(.ADDR_W(ADDR_W), .TRACE_DEPTH(DEPTH)) ret_if ();

   xgriscv_retire_monitor #(
      .ADDR_W(ADDR_W), .END_PC(END_PC), .WDOG_CYCLES(WDOG), .CNT_W(CNT_W), .TRACE_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn), .ret_if(ret_if),
      .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc);
      ret_if.retire_valid = 1'b1;
      ret_if.retire_pc    = pc;
      tick();
      ret_if.retire_valid = 1'b0;
   endtask

   task automatic do_reset();
      rstn                = 1'b1;
      ret_if.retire_valid = 1'b0;
      ret_if.retire_pc    = '0;
      ret_if.trace_rd_en  = 1'b0;
      tick();
      tick();
      rstn = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_done",    done,       0);
      check("rst_timeout", timeout,    0);
      check("rst_cycle",   cycle_cnt,  0);
      check("rst_retire",  retire_cnt, 0);
      check("rst_tcount",  ret_if.trace_count,    0);
      check("rst_tvalid",  ret_if.trace_rd_valid, 0);

      // Normal end: 0x80000000..0x80000078, one retire per cycle
      for (int i = 0; i < 31; i++) begin
         if (i == 30) check("t2_done_before_end", done, 0);
         retire(32'h80000000 + 32'(4 * i));
         if (i == 9) begin
            check("t2_retire_mid", retire_cnt, 10);
            check("t2_cycle_mid",  cycle_cnt,  10);
         end
      end
      check("t2_done",    done,       1);
      check("t2_timeout", timeout,    0);
      check("t2_retire",  retire_cnt, 31);
      check("t2_cycle",   cycle_cnt,  31);

      // Post-end retires and idle cycles are ignored
      for (int i = 0; i < 3; i++) retire(32'h80000010);
      repeat (20) tick();
      check("t5_retire",  retire_cnt, 31);
      check("t5_cycle",   cycle_cnt,  31);
      check("t5_done",    done,       1);
      check("t5_timeout", timeout,    0);

      // Asynchronous reset in the middle of a clock period
      #3;
      rstn = 1'b1;
      #1;
      check("t1_done_async",   done,       0);
      check("t1_cycle_async",  cycle_cnt,  0);
      check("t1_retire_async", retire_cnt, 0);
      tick();
      rstn = 1'b0;
      retire(32'h80000000);
      retire(32'h80000004);
      check("t1_retire_restart", retire_cnt, 2);
      check("t1_cycle_restart",  cycle_cnt,  2);

      // Hang: five retires in total, then silence
      retire(32'h80000008);
      retire(32'h8000000c);
      retire(32'h80000010);
      check("t3_retire5", retire_cnt, 5);
      repeat (15) tick();
      check("t3_timeout_15", timeout,   0);
      check("t3_cycle_15",   cycle_cnt, 20);
      tick();
      check("t3_timeout_16", timeout,    1);
      check("t3_cycle_16",   cycle_cnt,  21);
      check("t3_retire_16",  retire_cnt, 5);
      check("t3_done",       done,       0);
      repeat (5) tick();
      retire(END_PC);
      check("t3_cycle_frozen",  cycle_cnt,  21);
      check("t3_retire_frozen", retire_cnt, 5);
      check("t3_done_ignored",  done,       0);
      check("t3_timeout_stick", timeout,    1);

      // Race: END_PC retires on the expiry cycle
      do_reset();
      for (int i = 0; i < 3; i++) retire(32'h80000000 + 32'(4 * i));
      repeat (15) tick();
      check("t4_timeout_15", timeout, 0);
      retire(END_PC);
      check("t4_done",    done,       1);
      check("t4_timeout", timeout,    0);
      check("t4_retire",  retire_cnt, 4);
      check("t4_cycle",   cycle_cnt,  19);

      // Watchdog from reset exit with no retire at all
      do_reset();
      repeat (15) tick();
      check("wd_reset_15", timeout,   0);
      check("wd_cycle_15", cycle_cnt, 15);
      tick();
      check("wd_reset_16",  timeout,    1);
      check("wd_cycle_16",  cycle_cnt,  16);
      check("wd_retire_16", retire_cnt, 0);

      // Trace history
      do_reset();
`ifdef RETIRE_TRACE_EN
      for (int i = 0; i < 10; i++) retire(32'h100 + 32'(4 * i));
      check("t6_count_full", ret_if.trace_count, DEPTH);
      ret_if.trace_rd_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("t6_pop_valid", ret_if.trace_rd_valid, 1);
         check("t6_pop_data",  ret_if.trace_rd_data,  32'h108 + 32'(4 * k));
         check("t6_pop_count", ret_if.trace_count,    7 - k);
      end
      tick();
      check("t6_empty_valid", ret_if.trace_rd_valid, 0);
      check("t6_empty_count", ret_if.trace_count,    0);
      check("t6_empty_hold",  ret_if.trace_rd_data,  32'h124);
      ret_if.trace_rd_en = 1'b0;
`else
      ret_if.trace_rd_en = 1'b1;
      retire(32'h100);
      tick();
      check("t6_off_data",  ret_if.trace_rd_data,  0);
      check("t6_off_valid", ret_if.trace_rd_valid, 0);
      check("t6_off_count", ret_if.trace_count,    0);
      ret_if.trace_rd_en = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
